// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//
// Enumerates every gate sequence of length L over NUM_GATES gate codes in
// odometer order (index 0 is the least significant digit and changes fastest).
// Items (index, gate) are handed to the sequence multiplier one at a time,
// highest index first. After the first sequence, only the indices that changed
// are re-emitted, so the multiplier can reuse its per-index result cache.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-low reset (0 = reset)
//   start      in   begin enumeration; sampled in IDLE only
//   length     in   sequence length L, latched when start is accepted
//   pause      in   1 = issue no new item
//   available  in   multiplier can accept an item
//   seq_index  out  index of the current item
//   seq_gate   out  gate code of the current item
//   ready      out  1-cycle strobe: item valid
//   first      out  item is index L-1 (multiplier loads it, no multiply)
//   busy       out  high from start accept until finished
//   finished   out  1-cycle pulse: all NUM_GATES^L sequences consumed
//   error      out  1-cycle pulse: start with length 0 or > MAX_LENGTH
//   seq_count  out  complete sequences issued since last start (wraps)
// -----------------------------------------------------------------------------
module sequence_generator #(
    parameter int SEQ_INDEX_BITS = 5,
    parameter int MAX_LENGTH     = 5,
    parameter int NUM_GATES      = 6,
    parameter int COUNT_BITS     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SEQ_INDEX_BITS-1:0] length,
    input  logic                      pause,
    input  logic                      available,
    output logic [SEQ_INDEX_BITS-1:0] seq_index,
    output logic [4:0]                seq_gate,
    output logic                      ready,
    output logic                      first,
    output logic                      busy,
    output logic                      finished,
    output logic                      error,
    output logic [COUNT_BITS-1:0]     seq_count
);

    // Enough bits to address the digit storage.
    localparam int DEPTH_BITS = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [4:0] GATE_MAX = 5'(NUM_GATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                    state;
    logic [SEQ_INDEX_BITS-1:0] len_q;   // latched L
    logic [SEQ_INDEX_BITS-1:0] nxt;     // index of the next item to issue
    logic                      fpend;   // next item is the top index of a sequence
    logic [4:0]                digit [MAX_LENGTH];

    logic                      start_legal;
    logic                      carry_found;
    logic [SEQ_INDEX_BITS-1:0] carry_k;

    assign start_legal = (length != '0) && (length <= SEQ_INDEX_BITS'(MAX_LENGTH));

    // Lowest digit below L that is not yet at its maximum: the odometer
    // increments it and clears everything below. Scanning downward lets the
    // lowest match overwrite any higher one.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        carry_found = 1'b0;
        carry_k     = '0;
        for (int i = MAX_LENGTH - 1; i >= 0; i--) begin
            if ((SEQ_INDEX_BITS'(i) < len_q) && (digit[i] != GATE_MAX)) begin
                carry_found = 1'b1;
                carry_k     = SEQ_INDEX_BITS'(i);
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            len_q     <= '0;
            nxt       <= '0;
            fpend     <= 1'b0;
            seq_index <= '0;
            seq_gate  <= '0;
            ready     <= 1'b0;
            first     <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            error     <= 1'b0;
            seq_count <= '0;
            // NOTE: the digit storage is a handful of flops, not a RAM, so it
            // is cleared by reset like any other register.
            for (int i = 0; i < MAX_LENGTH; i++) begin
                digit[i] <= '0;
            end
        end else begin
            // Strobes default low; the states below raise them for one cycle.
            ready    <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            len_q     <= length;
                            nxt       <= length - 1'b1;
                            fpend     <= 1'b1;
                            seq_count <= '0;
                            busy      <= 1'b1;
                            for (int i = 0; i < MAX_LENGTH; i++) begin
                                digit[i] <= '0;
                            end
                            state     <= S_WAIT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    if (available && !pause) begin
                        seq_index <= nxt;
                        seq_gate  <= digit[nxt[DEPTH_BITS-1:0]];
                        first     <= fpend;
                        ready     <= 1'b1;
                        state     <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (seq_index != '0) begin
                        // Walk down toward index 0 within the current sequence.
                        nxt   <= seq_index - 1'b1;
                        fpend <= 1'b0;
                        state <= S_WAIT;
                    end else begin
                        // Index 0 closes a sequence; advance the odometer.
                        seq_count <= seq_count + 1'b1;
                        if (carry_found) begin
                            for (int j = 0; j < MAX_LENGTH; j++) begin
                                if (SEQ_INDEX_BITS'(j) < carry_k) begin
                                    digit[j] <= '0;
                                end else if (SEQ_INDEX_BITS'(j) == carry_k) begin
                                    digit[j] <= digit[j] + 5'd1;
                                end
                            end
                            nxt   <= carry_k;
                            fpend <= (carry_k == len_q - 1'b1);
                            state <= S_WAIT;
                        end else begin
                            // Every digit at maximum: enumeration is complete.
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // Wait until the multiplier has taken the last item.
                    if (available) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
